// File: rtl/lsq_mem_arbiter_pkg.sv
// Shared constants for the LSQ data-cache port: funct3 encodings, the FSM
// state type and the default tag width.
package lsq_mem_arbiter_pkg;

  localparam int TAG_WIDTH_DEF = 6;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    LSQ_IDLE  = 3'd0,
    LSQ_REQ   = 3'd1,
    LSQ_WAIT  = 3'd2,
    LSQ_RESP  = 3'd3,
    LSQ_DRAIN = 3'd4
  } lsq_mem_state_e;

endpackage

// File: rtl/mem_align_unit.sv
// Combinational lane steering: store byte enables and shifted write data,
// load byte/half extraction with sign or zero extension.
module mem_align_unit
  import lsq_mem_arbiter_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shift;

  assign st_wdata_o = st_data_i << {st_off_i, 3'b000};
  assign ld_shift   = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    st_be_o = 4'hF;
    case (st_funct3_i)
      F3_SB:   st_be_o = 4'b0001 << st_off_i;
      F3_SH:   st_be_o = 4'b0011 << st_off_i;
      default: st_be_o = 4'hF;
    endcase
  end

  // Unlisted encodings fall through to a full-word pass.
  always_comb begin
    ld_data_o = ld_shift;
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_LH:   ld_data_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_LBU:  ld_data_o = {24'b0, ld_shift[7:0]};
      F3_LHU:  ld_data_o = {16'b0, ld_shift[15:0]};
      default: ld_data_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/lsq_mem_arbiter.sv
// Single dcache port shared by load issue and committed-store drain: load
// priority with a starvation guard, one access in flight at a time.
module lsq_mem_arbiter
  import lsq_mem_arbiter_pkg::*;
#(
  parameter int TAG_WIDTH    = TAG_WIDTH_DEF,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ld_req_valid,
  output logic                  ld_req_ready,
  input  logic [ADDR_WIDTH-1:0] ld_req_addr,
  input  logic [2:0]            ld_req_funct3,
  input  logic [TAG_WIDTH-1:0]  ld_req_tag,
  input  logic                  st_req_valid,
  output logic                  st_req_ready,
  input  logic [ADDR_WIDTH-1:0] st_req_addr,
  input  logic [31:0]           st_req_data,
  input  logic [2:0]            st_req_funct3,
  input  logic [TAG_WIDTH-1:0]  st_req_tag,
  input  logic                  st_urgent,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [31:0]           mem_req_wdata,
  output logic [3:0]            mem_req_be,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_rdata,
  output logic                  ld_resp_valid,
  input  logic                  ld_resp_ready,
  output logic [TAG_WIDTH-1:0]  ld_resp_tag,
  output logic [31:0]           ld_resp_data,
  output logic                  st_done_valid,
  output logic [TAG_WIDTH-1:0]  st_done_tag
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  lsq_mem_state_e          state_q, state_d;
  logic [CNT_W-1:0]        starve_q, starve_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [2:0]              f3_q, f3_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    st_done_q, st_done_d;

  logic                    idle, st_pick, st_go, ld_go;
  logic [3:0]              al_be;
  logic [31:0]             al_wdata, al_ld_data;

  mem_align_unit u_align (
    .st_funct3_i (st_req_funct3),
    .st_off_i    (st_req_addr[1:0]),
    .st_data_i   (st_req_data),
    .st_be_o     (al_be),
    .st_wdata_o  (al_wdata),
    .ld_funct3_i (f3_q),
    .ld_off_i    (addr_q[1:0]),
    .ld_rdata_i  (mem_resp_rdata),
    .ld_data_o   (al_ld_data)
  );

  // Readies are held low while reset is asserted, not just after the edge.
  assign idle    = (state_q == LSQ_IDLE) && !rst;
  assign st_pick = st_req_valid && (st_urgent || (starve_q == CNT_MAX) || !ld_req_valid);
  assign st_go   = st_req_valid && st_req_ready;
  assign ld_go   = ld_req_valid && ld_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LSQ_IDLE;
      starve_q  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      tag_q     <= '0;
      f3_q      <= '0;
      rdata_q   <= '0;
      st_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      tag_q     <= tag_d;
      f3_q      <= f3_d;
      rdata_q   <= rdata_d;
      st_done_q <= st_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    tag_d         = tag_q;
    f3_d          = f3_q;
    rdata_d       = rdata_q;
    st_done_d     = 1'b0;
    st_req_ready  = idle && st_pick;
    ld_req_ready  = idle && !st_pick && !flush;
    mem_req_valid = 1'b0;
    ld_resp_valid = 1'b0;

    if (!st_req_valid || st_go)
      starve_d = '0;
    else if (ld_go && (starve_q != CNT_MAX))
      starve_d = starve_q + 1'b1;

    case (state_q)
      LSQ_IDLE: begin
        if (st_go) begin
          we_d    = 1'b1;
          addr_d  = st_req_addr;
          wdata_d = al_wdata;
          be_d    = al_be;
          tag_d   = st_req_tag;
          f3_d    = st_req_funct3;
          state_d = LSQ_REQ;
        end else if (ld_go) begin
          we_d    = 1'b0;
          addr_d  = ld_req_addr;
          wdata_d = '0;
          be_d    = 4'hF;
          tag_d   = ld_req_tag;
          f3_d    = ld_req_funct3;
          state_d = LSQ_REQ;
        end
      end
      LSQ_REQ: begin
        mem_req_valid = 1'b1;
        if (we_q) begin
          // Committed stores are not speculative, so flush is ignored here.
          if (mem_req_ready) begin
            st_done_d = 1'b1;
            state_d   = LSQ_IDLE;
          end
        end else if (flush) begin
          state_d = mem_req_ready ? LSQ_DRAIN : LSQ_IDLE;
        end else if (mem_req_ready) begin
          state_d = LSQ_WAIT;
        end
      end
      LSQ_WAIT: begin
        if (mem_resp_valid) begin
          if (flush) begin
            state_d = LSQ_IDLE;
          end else begin
            rdata_d = al_ld_data;
            state_d = LSQ_RESP;
          end
        end else if (flush) begin
          state_d = LSQ_DRAIN;
        end
      end
      LSQ_RESP: begin
        ld_resp_valid = 1'b1;
        if (flush || ld_resp_ready) state_d = LSQ_IDLE;
      end
      LSQ_DRAIN: begin
        if (mem_resp_valid) state_d = LSQ_IDLE;
      end
      default: state_d = LSQ_IDLE;
    endcase
  end

  assign mem_req_we    = we_q;
  assign mem_req_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_req_wdata = wdata_q;
  assign mem_req_be    = be_q;
  assign ld_resp_tag   = tag_q;
  assign ld_resp_data  = rdata_q;
  assign st_done_valid = st_done_q;
  // tag_q still holds the store's tag in the cycle after acceptance.
  assign st_done_tag   = tag_q;

endmodule
